// File: rtl/mdio_phy_manager_if.sv
// AXI-Lite channel bundle between the PHY manager and the MDIO master.
// Master drives requests; Slave answers.
interface axi_lite_interface;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport Master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid,
    input  arready, rdata, rresp, rvalid
  );

  modport Slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arvalid, rready,
    output awready, wready, bresp, bvalid,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/mdio_phy_manager.sv
// Self-running PHY supervisor: one BMCR write after reset, then periodic BMSR polls.
// Optional link debounce: define MDIO_PHY_MANAGER_LINK_DEBOUNCE_EN.
module mdio_phy_manager #(
  parameter int          STARTUP_CYCLES = 1_250_000,
  parameter int          POLL_CYCLES    = 125_000,
  parameter int          TIMEOUT_CYCLES = 16_384,
  parameter logic [15:0] INIT_BMCR      = 16'h1140
) (
  input  logic              clk,
  input  logic              reset,
  axi_lite_interface.Master axi_lite,
  input  logic              err_clear,
  output logic              link_up,
  output logic              an_complete,
  output logic              link_change,
  output logic              status_valid,
  output logic [15:0]       bmsr,
  output logic [1:0]        err
);

  localparam int WMAX = (STARTUP_CYCLES > POLL_CYCLES) ?
                        STARTUP_CYCLES : POLL_CYCLES;
  localparam int WCW  = $clog2(WMAX + 1);
  localparam int TCW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_STARTUP,
    S_WR_REQ,
    S_WR_RESP,
    S_POLL_WAIT,
    S_RD_REQ,
    S_RD_RESP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WCW-1:0]   r_wait_cnt;
  logic [TCW-1:0]   r_to_cnt;
  logic             r_aw_done;
  logic             r_w_done;
  logic             r_link_up;
  logic             r_an;
  logic             r_link_chg;
  logic             r_sv;
  logic [15:0]      r_bmsr;
  logic [1:0]       r_err;

  logic w_awvalid;
  logic w_wvalid;
  logic w_bready;
  logic w_arvalid;
  logic w_rready;
  logic w_to_hit;
  logic w_to_err;
  logic w_chg;
  logic w_waiting;
  logic w_guarded;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_rd_hs;
  logic w_rd_ok;
  logic w_link_nxt;
  logic [1:0] w_err_set;
  logic w_unused;

  assign w_to_hit = (r_to_cnt == TCW'(TIMEOUT_CYCLES - 1));
  assign w_aw_hs  = w_awvalid && axi_lite.awready;
  assign w_w_hs   = w_wvalid && axi_lite.wready;
  assign w_b_hs   = w_bready && axi_lite.bvalid;
  assign w_rd_hs  = w_rready && axi_lite.rvalid;
  assign w_rd_ok  = w_rd_hs && (axi_lite.rresp == 2'b00);
  assign w_unused = ^{axi_lite.rdata[31:16]};

  always_comb begin
    w_next    = r_state;
    w_awvalid = 1'b0;
    w_wvalid  = 1'b0;
    w_bready  = 1'b0;
    w_arvalid = 1'b0;
    w_rready  = 1'b0;
    w_to_err  = 1'b0;
    unique case (r_state)
      S_STARTUP: begin
        if (r_wait_cnt == WCW'(STARTUP_CYCLES - 1))
          w_next = S_WR_REQ;
      end
      S_WR_REQ: begin
        w_awvalid = !r_aw_done;
        w_wvalid  = !r_w_done;
        if ((r_aw_done || (!r_aw_done && axi_lite.awready)) &&
            (r_w_done || (!r_w_done && axi_lite.wready))) begin
          w_next = S_WR_RESP;
        end else if (w_to_hit) begin
          w_next   = S_POLL_WAIT;
          w_to_err = 1'b1;
        end
      end
      S_WR_RESP: begin
        w_bready = 1'b1;
        if (axi_lite.bvalid) begin
          w_next = S_POLL_WAIT;
        end else if (w_to_hit) begin
          w_next   = S_POLL_WAIT;
          w_to_err = 1'b1;
        end
      end
      S_POLL_WAIT: begin
        if (r_wait_cnt == WCW'(POLL_CYCLES - 1))
          w_next = S_RD_REQ;
      end
      S_RD_REQ: begin
        w_arvalid = 1'b1;
        if (axi_lite.arready) begin
          w_next = S_RD_RESP;
        end else if (w_to_hit) begin
          w_next   = S_POLL_WAIT;
          w_to_err = 1'b1;
        end
      end
      S_RD_RESP: begin
        w_rready = 1'b1;
        if (axi_lite.rvalid) begin
          w_next = S_POLL_WAIT;
        end else if (w_to_hit) begin
          w_next   = S_POLL_WAIT;
          w_to_err = 1'b1;
        end
      end
      default: w_next = S_STARTUP;
    endcase
  end

  assign w_chg     = (w_next != r_state);
  assign w_waiting = (r_state == S_STARTUP) ||
                     (r_state == S_POLL_WAIT);
  assign w_guarded = (r_state == S_WR_REQ) ||
                     (r_state == S_WR_RESP) ||
                     (r_state == S_RD_REQ) ||
                     (r_state == S_RD_RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_STARTUP;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
      r_to_cnt   <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      r_wait_cnt <= (w_chg || !w_waiting) ? '0 : r_wait_cnt + WCW'(1);
      r_to_cnt   <= (w_chg || !w_guarded || w_to_hit) ?
                    '0 : r_to_cnt + TCW'(1);
      r_aw_done  <= (r_state == S_WR_REQ && !w_chg) &&
                    (r_aw_done || w_aw_hs);
      r_w_done   <= (r_state == S_WR_REQ && !w_chg) &&
                    (r_w_done || w_w_hs);
    end
  end

`ifdef MDIO_PHY_MANAGER_LINK_DEBOUNCE_EN
  // link_up moves only once two back-to-back good reads agree
  logic r_prev_bit;
  logic r_run_vld;

  assign w_link_nxt = (r_run_vld &&
                       r_prev_bit == axi_lite.rdata[2]) ?
                      axi_lite.rdata[2] : r_link_up;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_bit <= 1'b0;
      r_run_vld  <= 1'b0;
    end else if (w_rd_ok) begin
      r_prev_bit <= axi_lite.rdata[2];
      r_run_vld  <= 1'b1;
    end else if (w_rd_hs) begin
      r_run_vld  <= 1'b0;
    end
  end
`else
  assign w_link_nxt = axi_lite.rdata[2];
`endif

  assign w_err_set = {
    w_to_err,
    (w_b_hs && axi_lite.bresp != 2'b00) ||
    (w_rd_hs && axi_lite.rresp != 2'b00)
  };

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_link_up  <= 1'b0;
      r_an       <= 1'b0;
      r_link_chg <= 1'b0;
      r_sv       <= 1'b0;
      r_bmsr     <= '0;
      r_err      <= '0;
    end else begin
      r_link_chg <= 1'b0;
      if (w_rd_ok) begin
        r_bmsr     <= axi_lite.rdata[15:0];
        r_an       <= axi_lite.rdata[5];
        r_sv       <= 1'b1;
        r_link_up  <= w_link_nxt;
        r_link_chg <= (w_link_nxt != r_link_up);
      end
      // a fresh error outranks a same-cycle clear
      r_err <= (err_clear ? 2'b00 : r_err) | w_err_set;
    end
  end

  assign axi_lite.awvalid = w_awvalid;
  assign axi_lite.awaddr  = '0;
  assign axi_lite.wvalid  = w_wvalid;
  assign axi_lite.wdata   = w_wvalid ? {16'h0000, INIT_BMCR} : '0;
  assign axi_lite.wstrb   = w_wvalid ? 4'hF : 4'h0;
  assign axi_lite.bready  = w_bready;
  assign axi_lite.arvalid = w_arvalid;
  assign axi_lite.araddr  = w_arvalid ? 32'd1 : '0;
  assign axi_lite.rready  = w_rready;

  assign link_up      = r_link_up;
  assign an_complete  = r_an;
  assign link_change  = r_link_chg;
  assign status_valid = r_sv;
  assign bmsr         = r_bmsr;
  assign err          = r_err;

endmodule
